// File: rtl/wts_pkg.sv
// Shared constants and FSM state type for the world-to-screen projector.
//   HORIZON/V_SPAN     : first ground row below the horizon and rows below it
//   H_CENTER/H_RES     : screen centre column and horizontal resolution
//   COS55_Q8/SIN55_Q8  : half field-of-view ray slope, Q8
//   POS_W/DIFF_W/ROT_W : widths of positions, differences and rotated coordinates
package wts_pkg;

  localparam int unsigned HORIZON  = 360;
  localparam int unsigned V_SPAN   = 360;
  localparam int unsigned H_CENTER = 640;
  localparam int unsigned H_RES    = 1280;
  localparam int unsigned COS55_Q8 = 146;
  localparam int unsigned SIN55_Q8 = 210;

  localparam int unsigned POS_W  = 24;
  localparam int unsigned DIFF_W = 25;
  localparam int unsigned ROT_W  = 42;

  typedef enum logic [2:0] {
    StIdle,
    StDiff,
    StRot,
    StDivV,
    StDivH,
    StDivS,
    StDone
  } wts_state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, exactly DIV_W cycles per division.
// The first step runs in the start cycle on the live operands, so a caller that holds start
// for one cycle gets the quotient on quo after DIV_W rising edges. quo holds until next start.
// A zero divisor yields an all-ones quotient.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a division this cycle (num/den sampled)
//   num, den   : dividend and divisor
//   busy       : a division started earlier is still stepping
//   last       : this cycle performs the final quotient step
//   quo        : quotient
module seq_divider #(
  parameter int unsigned DIV_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] num,
  input  logic [DIV_W-1:0] den,
  output logic             busy,
  output logic             last,
  output logic [DIV_W-1:0] quo
);

  localparam int unsigned CntW = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] acc_q, acc_d;  // dividend bits shift out at the top, quotient bits in below
  logic [DIV_W-1:0] den_q, den_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [DIV_W-1:0] rem_cur, acc_cur, den_cur;
  logic [DIV_W:0]   shifted;
  logic             take;

  always_comb begin
    rem_cur = start ? '0  : rem_q;
    acc_cur = start ? num : acc_q;
    den_cur = start ? den : den_q;
    shifted = {rem_cur, acc_cur[DIV_W-1]};
    take    = (shifted >= {1'b0, den_cur});

    rem_d = rem_q;
    acc_d = acc_q;
    den_d = den_q;
    cnt_d = cnt_q;
    run_d = run_q;
    last  = 1'b0;

    if (start || run_q) begin
      den_d = den_cur;
      rem_d = take ? DIV_W'(shifted - {1'b0, den_cur}) : shifted[DIV_W-1:0];
      acc_d = {acc_cur[DIV_W-2:0], take};
      cnt_d = start ? CntW'(1) : cnt_q + CntW'(1);
      last  = (cnt_d == CntW'(DIV_W));
      run_d = !last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      acc_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      acc_q <= acc_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign busy = run_q;
  assign quo  = acc_q;

endmodule

// File: rtl/world_to_screen_proj.sv
// Projects a world point (Q20.4 map pixels) onto the 1280x720 view using the ground renderer's
// row-depth law and +/-55 degree view rays. One request per start/valid handshake, fixed latency
// independent of data: valid_out rises 2*DIV_W+4 cycles after accept (3*DIV_W+4 with
// WTS_SCALE_EN defined, which adds the sprite-radius division and drives scale_out).
//   pixel_clk_in, rst_n_in          : clock, asynchronous active-low reset
//   start_in                        : request, accepted only when idle
//   cam_x_in/cam_y_in, obj_x_in/... : camera and object position, unsigned Q20.4
//   cos_abs_in/sin_abs_in           : heading magnitudes, Q8; *_sign_in = 1 means negative
//   near_mag_in/far_mag_in          : near/far distances, integer map pixels
//   busy_out                        : accept through the valid cycle
//   valid_out                       : one-cycle result strobe; result fields held afterwards
//   visible_out, screen_h_out/v_out : on-screen flag and pixel (0 when not visible)
//   scale_out                       : saturated sprite radius (0 unless WTS_SCALE_EN)
module world_to_screen_proj
  import wts_pkg::*;
#(
  parameter int unsigned DIV_W      = 48,
  parameter int unsigned OBJ_RADIUS = 2
) (
  input  logic              pixel_clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [POS_W-1:0]  cam_x_in,
  input  logic [POS_W-1:0]  cam_y_in,
  input  logic [POS_W-1:0]  obj_x_in,
  input  logic [POS_W-1:0]  obj_y_in,
  input  logic [15:0]       cos_abs_in,
  input  logic [15:0]       sin_abs_in,
  input  logic              cos_sign_in,
  input  logic              sin_sign_in,
  input  logic [15:0]       near_mag_in,
  input  logic [15:0]       far_mag_in,
  output logic              busy_out,
  output logic              valid_out,
  output logic              visible_out,
  output logic [10:0]       screen_h_out,
  output logic [9:0]        screen_v_out,
  output logic [7:0]        scale_out
);

  localparam logic [63:0] SNumFull = 64'(H_CENTER) * 64'(COS55_Q8) * 64'(OBJ_RADIUS) * 64'(4096);
  localparam logic [DIV_W-1:0] SNum = DIV_W'(SNumFull);

  wts_state_t state_q, state_d;

  // Latched request
  logic [POS_W-1:0] cam_x_q, cam_y_q, obj_x_q, obj_y_q;
  logic [15:0]      cos_abs_q, sin_abs_q, near_q, far_q;
  logic             cos_sign_q, sin_sign_q;

  logic signed [DIFF_W-1:0] dx_q, dy_q, dx_d, dy_d;
  logic signed [ROT_W-1:0]  f_q, l_q, f_d, l_d;
  logic signed [16:0]       cos_s, sin_s;
  logic [DIV_W-1:0]         qv_q;
`ifdef WTS_SCALE_EN
  logic [DIV_W-1:0]         qh_q;
  logic [DIV_W-1:0]         qs;
  logic [7:0]               scale_q, scale_d;
`endif

  logic        valid_q, vis_q, vis_d;
  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;

  // Divider operands and handshake
  logic             div_start, div_busy, div_last, in_div;
  logic [DIV_W-1:0] div_num, div_den, div_quo;

  logic signed [ROT_W-1:0] near_q12, far_q12, v_den_s;
  logic [15:0]             span;
  logic [DIV_W-1:0]        v_num, v_den, h_num, h_den, qh, h_lim;
  logic [ROT_W-1:0]        l_abs, f_pos;
  logic [63:0]             h_num_full, h_den_full;
  logic                    h_ovf, l_neg, f_gt0;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_in) state_d = StDiff;
      StDiff:  state_d = StRot;
      StRot:   state_d = StDivV;
      StDivV:  if (div_last) state_d = StDivH;
`ifdef WTS_SCALE_EN
      StDivH:  if (div_last) state_d = StDivS;
`else
      StDivH:  if (div_last) state_d = StDone;
`endif
      StDivS:  if (div_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // ---------------------------------------------------------------- Difference and rotation
  always_comb begin
    dx_d  = $signed({1'b0, obj_x_q}) - $signed({1'b0, cam_x_q});
    dy_d  = $signed({1'b0, obj_y_q}) - $signed({1'b0, cam_y_q});
    cos_s = cos_sign_q ? -$signed({1'b0, cos_abs_q}) : $signed({1'b0, cos_abs_q});
    sin_s = sin_sign_q ? -$signed({1'b0, sin_abs_q}) : $signed({1'b0, sin_abs_q});
    f_d   = ROT_W'(dx_q) * ROT_W'(cos_s) - ROT_W'(dy_q) * ROT_W'(sin_s);
    l_d   = ROT_W'(dx_q) * ROT_W'(sin_s) + ROT_W'(dy_q) * ROT_W'(cos_s);
  end

  // ---------------------------------------------------------------- Divider operands
  always_comb begin
    near_q12 = $signed(ROT_W'({near_q, 12'd0}));
    far_q12  = $signed(ROT_W'({far_q, 12'd0}));
    f_gt0    = !f_q[ROT_W-1] && (f_q != '0);

    span     = (far_q >= near_q) ? far_q - near_q : '0;
    v_num    = DIV_W'(64'(span) * 64'(V_SPAN) * 64'(4096));
    v_den_s  = f_q - near_q12;
    // Points at or behind the near plane divide by zero and come back all-ones (off-screen).
    v_den    = (v_den_s[ROT_W-1] || v_den_s == '0) ? '0 : DIV_W'($unsigned(v_den_s));

    l_neg      = l_q[ROT_W-1];
    l_abs      = l_neg ? $unsigned(-l_q) : $unsigned(l_q);
    h_num_full = 64'(l_abs) * 64'(H_CENTER * COS55_Q8);
    // A lateral offset too wide for the dividend is far outside the view cone: off-screen.
    h_ovf      = |h_num_full[63:DIV_W];
    h_num      = h_ovf ? '1 : h_num_full[DIV_W-1:0];
    f_pos      = f_gt0 ? $unsigned(f_q) : '0;
    h_den_full = 64'(f_pos) * 64'(SIN55_Q8);
    h_den      = (|h_den_full[63:DIV_W]) ? '1 : h_den_full[DIV_W-1:0];

    // Scale operands sit on the default leg; only DIV_S ever starts a division with them.
    div_num = SNum;
    div_den = h_den;
    case (state_q)
      StDivV: begin
        div_num = v_num;
        div_den = v_den;
      end
      StDivH: begin
        div_num = h_num;
        div_den = h_den;
      end
      default: ;
    endcase
  end

  assign in_div    = (state_q == StDivV) || (state_q == StDivH) || (state_q == StDivS);
  // The divider goes idle after its last step, so an idle divider in a DIV state means entry.
  assign div_start = in_div && !div_busy;

  seq_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk   (pixel_clk_in),
    .rst_n (rst_n_in),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .busy  (div_busy),
    .last  (div_last),
    .quo   (div_quo)
  );

  // ---------------------------------------------------------------- Result
  always_comb begin
`ifdef WTS_SCALE_EN
    qh = qh_q;
    qs = div_quo;
`else
    qh = div_quo;
`endif
    h_lim = l_neg ? DIV_W'(H_CENTER) : DIV_W'(H_RES - 1 - H_CENTER);
    vis_d = (f_q > far_q12) && (qv_q <= DIV_W'(V_SPAN - 1)) && !h_ovf && (qh <= h_lim);
    h_d   = '0;
    v_d   = '0;
    if (vis_d) begin
      h_d = l_neg ? 11'(H_CENTER) - qh[10:0] : 11'(H_CENTER) + qh[10:0];
      v_d = 10'(HORIZON) + qv_q[9:0];
    end
`ifdef WTS_SCALE_EN
    scale_d = '0;
    if (vis_d) scale_d = (qs > DIV_W'(255)) ? 8'hff : qs[7:0];
`endif
  end

  // ---------------------------------------------------------------- Datapath registers
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cam_x_q    <= '0;
      cam_y_q    <= '0;
      obj_x_q    <= '0;
      obj_y_q    <= '0;
      cos_abs_q  <= '0;
      sin_abs_q  <= '0;
      cos_sign_q <= 1'b0;
      sin_sign_q <= 1'b0;
      near_q     <= '0;
      far_q      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      f_q        <= '0;
      l_q        <= '0;
      qv_q       <= '0;
`ifdef WTS_SCALE_EN
      qh_q       <= '0;
      scale_q    <= '0;
`endif
      valid_q    <= 1'b0;
      vis_q      <= 1'b0;
      h_q        <= '0;
      v_q        <= '0;
    end else begin
      if (state_q == StIdle && start_in) begin
        cam_x_q    <= cam_x_in;
        cam_y_q    <= cam_y_in;
        obj_x_q    <= obj_x_in;
        obj_y_q    <= obj_y_in;
        cos_abs_q  <= cos_abs_in;
        sin_abs_q  <= sin_abs_in;
        cos_sign_q <= cos_sign_in;
        sin_sign_q <= sin_sign_in;
        near_q     <= near_mag_in;
        far_q      <= far_mag_in;
      end
      if (state_q == StDiff) begin
        dx_q <= dx_d;
        dy_q <= dy_d;
      end
      if (state_q == StRot) begin
        f_q <= f_d;
        l_q <= l_d;
      end
      // Previous quotient is still on quo during the first cycle of the following division.
      if (state_q == StDivH && div_start) qv_q <= div_quo;
`ifdef WTS_SCALE_EN
      if (state_q == StDivS && div_start) qh_q <= div_quo;
`endif
      valid_q <= (state_q == StDone);
      if (state_q == StDone) begin
        vis_q <= vis_d;
        h_q   <= h_d;
        v_q   <= v_d;
`ifdef WTS_SCALE_EN
        scale_q <= scale_d;
`endif
      end
    end
  end

  assign busy_out     = (state_q != StIdle) || valid_q;
  assign valid_out    = valid_q;
  assign visible_out  = vis_q;
  assign screen_h_out = h_q;
  assign screen_v_out = v_q;
`ifdef WTS_SCALE_EN
  assign scale_out    = scale_q;
`else
  assign scale_out    = '0;
`endif

endmodule

// File: tb/tb_world_to_screen_proj.sv
module tb_world_to_screen_proj;

  localparam int unsigned DW  = 48;
  localparam int unsigned RAD = 2;
`ifdef WTS_SCALE_EN
  localparam int unsigned LAT      = 3 * DW + 4;
  localparam bit          SCALE_ON = 1'b1;
`else
  localparam int unsigned LAT      = 2 * DW + 4;
  localparam bit          SCALE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] cam_x, cam_y, obj_x, obj_y;
  logic [15:0] cos_abs, sin_abs, near_mag, far_mag;
  logic        cos_sign, sin_sign;
  logic        busy, valid, visible;
  logic [10:0] scr_h;
  logic [9:0]  scr_v;
  logic [7:0]  scale;

  world_to_screen_proj #(
    .DIV_W      (DW),
    .OBJ_RADIUS (RAD)
  ) dut (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .start_in     (start),
    .cam_x_in     (cam_x),
    .cam_y_in     (cam_y),
    .obj_x_in     (obj_x),
    .obj_y_in     (obj_y),
    .cos_abs_in   (cos_abs),
    .sin_abs_in   (sin_abs),
    .cos_sign_in  (cos_sign),
    .sin_sign_in  (sin_sign),
    .near_mag_in  (near_mag),
    .far_mag_in   (far_mag),
    .busy_out     (busy),
    .valid_out    (valid),
    .visible_out  (visible),
    .screen_h_out (scr_h),
    .screen_v_out (scr_v),
    .scale_out    (scale)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] cx, cy, ox, oy;
    logic [15:0] ca, sa;
    logic        cs, ss;
    logic [15:0] nr, fr;
    logic        vis;
    int          h, v, sc;   // sc is the radius the scale build must report
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Camera at (100,100), heading +x, near 0, far 17.
  function automatic vec_t mk(input int ox, input int oy, input bit vis, input int h, input int v,
                              input int sc);
    vec_t t;
    t.cx = 24'(100 * 16); t.cy = 24'(100 * 16);
    t.ox = 24'(ox * 16);  t.oy = 24'(oy * 16);
    t.ca = 16'd256; t.sa = 16'd0; t.cs = 1'b0; t.ss = 1'b0;
    t.nr = 16'd0;   t.fr = 16'd17;
    t.vis = vis; t.h = h; t.v = v; t.sc = sc;
    return t;
  endfunction

  // Projection computed straight from the geometry with wide integer arithmetic.
  function automatic vec_t model(input vec_t t);
    vec_t   r;
    longint dx, dy, c, s, f, l, al, nr, fr, qv, qh, qs, h, v, big;
    r   = t;
    big = longint'(64'd1 << DW) - 1;
    nr  = longint'(t.nr);
    fr  = longint'(t.fr);
    dx  = longint'(t.ox) - longint'(t.cx);
    dy  = longint'(t.oy) - longint'(t.cy);
    c   = t.cs ? -longint'(t.ca) : longint'(t.ca);
    s   = t.ss ? -longint'(t.sa) : longint'(t.sa);
    f   = dx * c - dy * s;
    l   = dx * s + dy * c;
    al  = (l < 0) ? -l : l;
    qv  = (f - nr * 4096 > 0) ? (360 * (fr - nr) * 4096) / (f - nr * 4096) : big;
    if (f > 0) begin
      qh = (640 * 146 * al) / (210 * f);
      qs = (640 * 146 * RAD * 4096) / (210 * f);
    end else begin
      qh = big;
      qs = big;
    end
    v = 360 + qv;
    h = (l < 0) ? 640 - qh : 640 + qh;
    r.vis = (f > fr * 4096) && (v <= 719) && (h >= 0) && (h <= 1279);
    r.h   = r.vis ? int'(h) : 0;
    r.v   = r.vis ? int'(v) : 0;
    r.sc  = r.vis ? ((qs > 255) ? 255 : int'(qs)) : 0;
    return r;
  endfunction

  task automatic drive(input vec_t t);
    cam_x = t.cx; cam_y = t.cy; obj_x = t.ox; obj_y = t.oy;
    cos_abs = t.ca; sin_abs = t.sa; cos_sign = t.cs; sin_sign = t.ss;
    near_mag = t.nr; far_mag = t.fr;
  endtask

  task automatic check_result(input string tag, input vec_t t);
    check({tag, ".visible"}, 64'(visible), 64'(t.vis));
    check({tag, ".h"}, 64'(scr_h), 64'(t.h));
    check({tag, ".v"}, 64'(scr_v), 64'(t.v));
    check({tag, ".scale"}, 64'(scale), SCALE_ON ? 64'(t.sc) : 64'd0);
  endtask

  // One request; k counts rising edges after the accept edge when valid is first seen.
  task automatic run_vec(input string tag, input vec_t t);
    int k;
    bit got;
    @(negedge clk);
    drive(t);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    k   = 0;
    got = 1'b0;
    while (!got && k < int'(LAT) + 20) begin
      if (valid) got = 1'b1;
      else begin
        @(posedge clk);
        k++;
        @(negedge clk);
      end
    end
    check({tag, ".latency"}, 64'(k), 64'(LAT - 1));
    check_result(tag, t);
    @(negedge clk);
    check({tag, ".pulse"}, 64'(valid), 64'd0);
    check({tag, ".idle"}, 64'(busy), 64'd0);
  endtask

  vec_t dir[6];
  vec_t rv;
  vec_t alt;

  initial begin
    int pulses;
    int cxp, cyp, offx, offy;
    vec_t got_v;

    rst_n = 1'b0;
    start = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0));

    // Reset state
    #12;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.valid", 64'(valid), 64'd0);
    check("reset.visible", 64'(visible), 64'd0);
    check("reset.h", 64'(scr_h), 64'd0);
    check("reset.v", 64'(scr_v), 64'd0);
    check("reset.scale", 64'(scale), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed points around a camera looking down +x
    dir[0] = mk(134, 100, 1, 640, 540, 26);
    dir[1] = mk(134, 110, 1, 770, 540, 26);
    dir[2] = mk(134,  90, 1, 510, 540, 26);
    dir[3] = mk( 90, 100, 0,   0,   0,  0);   // behind camera
    dir[4] = mk(117, 100, 0,   0,   0,  0);   // exactly at far distance
    dir[5] = mk(134, 200, 0,   0,   0,  0);   // beyond the right edge
    for (int i = 0; i < 6; i++) run_vec($sformatf("dir%0d", i), dir[i]);

    // Random heading, positions and depth range against the model
    for (int i = 0; i < 24; i++) begin
      cxp  = int'($urandom_range(1000, 4000));
      cyp  = int'($urandom_range(1000, 4000));
      offx = int'($urandom_range(0, 600)) - 300;
      offy = int'($urandom_range(0, 600)) - 300;
      rv.cx = 24'(cxp * 16 + int'($urandom_range(0, 15)));
      rv.cy = 24'(cyp * 16 + int'($urandom_range(0, 15)));
      rv.ox = 24'(int'(rv.cx) + offx * 16 + int'($urandom_range(0, 15)));
      rv.oy = 24'(int'(rv.cy) + offy * 16 + int'($urandom_range(0, 15)));
      rv.ca = 16'($urandom_range(0, 256));
      rv.sa = 16'($urandom_range(0, 256));
      rv.cs = 1'($urandom_range(0, 1));
      rv.ss = 1'($urandom_range(0, 1));
      rv.nr = 16'($urandom_range(0, 30));
      rv.fr = rv.nr + 16'($urandom_range(0, 40));
      run_vec($sformatf("rnd%0d", i), model(rv));
    end

    // Second start while busy and input changes after accept are both ignored
    alt = mk(134, 110, 1, 770, 540, 26);
    @(negedge clk);
    drive(dir[0]);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drive(alt);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    got_v  = mk(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3 * int'(LAT); c++) begin
      if (valid) begin
        pulses++;
        got_v.vis = visible;
        got_v.h   = int'(scr_h);
        got_v.v   = int'(scr_v);
        got_v.sc  = int'(scale);
      end
      @(negedge clk);
    end
    check("restart.pulses", 64'(pulses), 64'd1);
    check("restart.visible", 64'(got_v.vis), 64'(dir[0].vis));
    check("restart.h", 64'(got_v.h), 64'(dir[0].h));
    check("restart.v", 64'(got_v.v), 64'(dir[0].v));
    check("restart.scale", 64'(got_v.sc), SCALE_ON ? 64'(dir[0].sc) : 64'd0);

    // Reset in the middle of a division aborts without a result
    @(negedge clk);
    drive(dir[1]);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.valid", 64'(valid), 64'd0);
    check("abort.visible", 64'(visible), 64'd0);
    check("abort.h", 64'(scr_h), 64'd0);
    check("abort.v", 64'(scr_v), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < int'(LAT) + 10; c++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check("abort.pulses", 64'(pulses), 64'd0);
    run_vec("after_reset", dir[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
